// File: rtl/dds_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl_if
//   Bundle of the sweep controller's request/configuration inputs and its
//   DDS-facing outputs.
//
//   Ports (i_ = into the controller, o_ = out of the controller):
//     i_start      sweep launch request
//     i_abort      sweep cancel request
//     i_repeat_en  restart from start_inc after the stop_inc dwell
//     i_start_inc  first phase increment of the sweep   [INC_W]
//     i_stop_inc   last phase increment of the sweep    [INC_W]
//     i_step_inc   unsigned increment change per step   [INC_W]
//     i_dwell      cycles each increment is held        [DWELL_W]
//     o_phase_inc  registered phase-increment word      [INC_W]
//     o_load_freq  one-cycle pulse when o_phase_inc holds a new value
//     o_busy       high while a sweep is active
//     o_done       one-cycle pulse on single-sweep completion
//
//   master: the side that drives requests/configuration (host, testbench)
//   slave : the sweep controller itself
// ---------------------------------------------------------------------------
interface dds_sweep_ctrl_if #(
    parameter int INC_W   = 8,
    parameter int DWELL_W = 16
);
    logic               i_start;
    logic               i_abort;
    logic               i_repeat_en;
    logic [INC_W-1:0]   i_start_inc;
    logic [INC_W-1:0]   i_stop_inc;
    logic [INC_W-1:0]   i_step_inc;
    logic [DWELL_W-1:0] i_dwell;

    logic [INC_W-1:0]   o_phase_inc;
    logic               o_load_freq;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_abort, i_repeat_en,
        output i_start_inc, i_stop_inc, i_step_inc, i_dwell,
        input  o_phase_inc, o_load_freq, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_repeat_en,
        input  i_start_inc, i_stop_inc, i_step_inc, i_dwell,
        output o_phase_inc, o_load_freq, o_busy, o_done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep sequencer for a DDS. On launch it latches a sweep
//   configuration and issues a series of phase-increment words, stepping
//   from start_inc toward stop_inc by step_inc, holding each word for a
//   programmable dwell. The last word is clamped to stop_inc exactly.
//   Optionally the sweep repeats indefinitely until aborted.
//
//   Ports:
//     clk    system clock, all state changes on its rising edge
//     reset  synchronous reset, active-high
//     bus    dds_sweep_ctrl_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int INC_W   = 8,
    parameter int DWELL_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    dds_sweep_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;

    // Next increment toward stop, clamped to stop. The up path is computed
    // one bit wider so a carry out of INC_W bits is caught as a clamp rather
    // than wrapping; the down path clamps on borrow.
    function automatic logic [INC_W-1:0] f_next_inc(
        input logic [INC_W-1:0] cur,
        input logic [INC_W-1:0] step,
        input logic [INC_W-1:0] stop,
        input logic             up
    );
        logic [INC_W:0]   sum;
        logic [INC_W-1:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = cur - step;
        if (up) begin
            f_next_inc = (sum >= {1'b0, stop}) ? stop : sum[INC_W-1:0];
        end else begin
            f_next_inc = ((cur < step) || (diff <= stop)) ? stop : diff;
        end
    endfunction

    logic [1:0]         r_state;
    logic [INC_W-1:0]   r_phase;
    logic               r_load;
    logic               r_busy;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;

    // Configuration captured at launch; inputs are ignored afterwards.
    logic [INC_W-1:0]   r_cfg_start;
    logic [INC_W-1:0]   r_cfg_stop;
    logic [INC_W-1:0]   r_cfg_step;
    logic [DWELL_W-1:0] r_cfg_d;
    logic               r_cfg_rep;
    logic               r_cfg_up;

    logic [DWELL_W-1:0] w_launch_d;
    logic               w_dwell_end;
    logic               w_at_stop;
    logic [INC_W-1:0]   w_next;

    // A dwell of zero behaves as one cycle per word.
    assign w_launch_d = (bus.i_dwell == '0) ? DWELL_W'(1) : bus.i_dwell;

    // The ISSUE cycle is the first cycle of every dwell, so DWELL only covers
    // the remaining D-1 cycles. With D=1 the dwell ends in ISSUE itself.
    assign w_dwell_end = ((r_state == S_ISSUE) && (r_cfg_d == DWELL_W'(1))) ||
                         ((r_state == S_DWELL) && (r_cnt == '0));

    assign w_at_stop   = (r_phase == r_cfg_stop);
    assign w_next      = f_next_inc(r_phase, r_cfg_step, r_cfg_stop, r_cfg_up);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= INC_W'(1);
            r_load      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_cfg_start <= '0;
            r_cfg_stop  <= '0;
            r_cfg_step  <= '0;
            r_cfg_d     <= '0;
            r_cfg_rep   <= 1'b0;
            r_cfg_up    <= 1'b0;
        end else if (bus.i_abort) begin
            // Abort beats start, a pending step and a pending completion.
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Also reached in the done cycle, so a start sampled
                    // alongside done relaunches immediately.
                    if (bus.i_start) begin
                        r_cfg_start <= bus.i_start_inc;
                        r_cfg_stop  <= bus.i_stop_inc;
                        r_cfg_step  <= bus.i_step_inc;
                        r_cfg_d     <= w_launch_d;
                        r_cfg_rep   <= bus.i_repeat_en;
                        r_cfg_up    <= (bus.i_stop_inc >= bus.i_start_inc);
                        r_phase     <= bus.i_start_inc;
                        r_load      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE, S_DWELL: begin
                    if (w_dwell_end) begin
                        if (w_at_stop) begin
                            if (r_cfg_rep) begin
                                r_phase <= r_cfg_start;
                                r_load  <= 1'b1;
                                r_state <= S_ISSUE;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else if (r_cfg_step == '0) begin
                            // Zero step can never reach stop: park on the
                            // current word until aborted.
                            r_cnt   <= '0;
                            r_state <= S_DWELL;
                        end else begin
                            r_phase <= w_next;
                            r_load  <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_state == S_ISSUE) begin
                        r_cnt   <= r_cfg_d - DWELL_W'(2);
                        r_state <= S_DWELL;
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_phase_inc = r_phase;
    assign bus.o_load_freq = r_load;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Directed bench for dds_sweep_ctrl. Each scenario launches a sweep,
//   records every load_freq pulse (cycle, value) and done pulse over a fixed
//   window, and compares them with hand-computed expectations. Cycle 0 of a
//   window is the first cycle after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic clk;
    logic reset;

    dds_sweep_ctrl_if #(.INC_W(8), .DWELL_W(16)) bus ();

    dds_sweep_ctrl #(.INC_W(8), .DWELL_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int q_cyc[$];
    int q_val[$];
    int q_done[$];
    int q_dbusy[$];
    int n_both;

    int e_cyc[$];
    int e_val[$];
    int e_done[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int s, input int e, input int st, input int dw, input int rep);
        bus.i_start_inc = 8'(s);
        bus.i_stop_inc  = 8'(e);
        bus.i_step_inc  = 8'(st);
        bus.i_dwell     = 16'(dw);
        bus.i_repeat_en = rep[0];
        bus.i_start     = 1'b1;
    endtask

    // Run ncyc cycles recording pulses. start is dropped after the launch
    // edge; at cycle poke it is raised again for one edge with start_inc
    // set to poke_val (poke < 0 disables this).
    task automatic capture(input int ncyc, input int poke, input int poke_val);
        q_cyc.delete(); q_val.delete(); q_done.delete(); q_dbusy.delete();
        n_both = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (bus.o_load_freq) begin
                q_cyc.push_back(i);
                q_val.push_back(int'(bus.o_phase_inc));
            end
            if (bus.o_done) begin
                q_done.push_back(i);
                q_dbusy.push_back(int'(bus.o_busy));
            end
            if (bus.o_load_freq && bus.o_done) n_both++;
            if (i == 0) bus.i_start = 1'b0;
            if (i == poke) begin
                bus.i_start     = 1'b1;
                bus.i_start_inc = 8'(poke_val);
            end
            if (i == poke + 1) bus.i_start = 1'b0;
        end
    endtask

    task automatic e_clear();
        e_cyc.delete(); e_val.delete(); e_done.delete();
    endtask

    task automatic e_load(input int c, input int v);
        e_cyc.push_back(c);
        e_val.push_back(v);
    endtask

    task automatic check_run(input string tag);
        chk($sformatf("%s nload", tag), q_cyc.size(), e_cyc.size());
        for (int k = 0; k < e_cyc.size() && k < q_cyc.size(); k++) begin
            chk($sformatf("%s load%0d cyc", tag, k), q_cyc[k], e_cyc[k]);
            chk($sformatf("%s load%0d val", tag, k), q_val[k], e_val[k]);
        end
        chk($sformatf("%s ndone", tag), q_done.size(), e_done.size());
        for (int k = 0; k < e_done.size() && k < q_done.size(); k++) begin
            chk($sformatf("%s done%0d cyc", tag, k), q_done[k], e_done[k]);
            chk($sformatf("%s done%0d busy", tag, k), q_dbusy[k], 0);
        end
        chk($sformatf("%s load_and_done", tag), n_both, 0);
    endtask

    task automatic do_abort(input string tag, input int held);
        bus.i_abort = 1'b1;
        tick();
        chk($sformatf("%s busy", tag), bus.o_busy, 0);
        chk($sformatf("%s load", tag), bus.o_load_freq, 0);
        chk($sformatf("%s done", tag), bus.o_done, 0);
        chk($sformatf("%s phase", tag), bus.o_phase_inc, held);
        bus.i_abort = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_repeat_en = 1'b0;
        bus.i_start_inc = '0;
        bus.i_stop_inc  = '0;
        bus.i_step_inc  = '0;
        bus.i_dwell     = '0;
        tick();
        tick();
        chk("rst phase", bus.o_phase_inc, 1);
        chk("rst load", bus.o_load_freq, 0);
        chk("rst busy", bus.o_busy, 0);
        chk("rst done", bus.o_done, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("idle busy", bus.o_busy, 0);

        // Up sweep, single pass.
        cfg(10, 40, 10, 4, 0);
        capture(20, -1, 0);
        e_clear();
        e_load(0, 10); e_load(4, 20); e_load(8, 30); e_load(12, 40);
        e_done.push_back(16);
        check_run("up");
        chk("up busy_end", bus.o_busy, 0);
        chk("up phase_end", bus.o_phase_inc, 40);

        // Down sweep with clamp on underflow, dwell 1.
        cfg(200, 5, 60, 1, 0);
        capture(8, -1, 0);
        e_clear();
        e_load(0, 200); e_load(1, 140); e_load(2, 80); e_load(3, 20); e_load(4, 5);
        e_done.push_back(5);
        check_run("down");

        // Overflow clamp with repeat; then abort.
        cfg(250, 255, 10, 2, 1);
        capture(12, -1, 0);
        e_clear();
        e_load(0, 250); e_load(2, 255); e_load(4, 250);
        e_load(6, 255); e_load(8, 250); e_load(10, 255);
        check_run("repeat");
        chk("repeat busy", bus.o_busy, 1);
        do_abort("repeat abort", 255);

        // Abort 30 cycles into a long dwell.
        cfg(7, 50, 1, 100, 0);
        capture(30, -1, 0);
        e_clear();
        e_load(0, 7);
        check_run("longdwell");
        do_abort("mid abort", 7);
        capture(150, -1, 0);
        e_clear();
        check_run("post abort");
        chk("post abort phase", bus.o_phase_inc, 7);

        // Dwell of zero behaves as one.
        cfg(3, 6, 1, 0, 0);
        capture(7, -1, 0);
        e_clear();
        e_load(0, 3); e_load(1, 4); e_load(2, 5); e_load(3, 6);
        e_done.push_back(4);
        check_run("dwell0");

        // Zero step holds start_inc until abort.
        cfg(10, 20, 0, 2, 0);
        capture(20, -1, 0);
        e_clear();
        e_load(0, 10);
        check_run("step0");
        chk("step0 busy", bus.o_busy, 1);
        do_abort("step0 abort", 10);

        // Start (with a different start_inc) while busy is ignored.
        cfg(10, 40, 10, 4, 0);
        capture(20, 5, 99);
        e_clear();
        e_load(0, 10); e_load(4, 20); e_load(8, 30); e_load(12, 40);
        e_done.push_back(16);
        check_run("busy start");

        // Start together with abort in IDLE does not launch.
        cfg(10, 40, 10, 4, 0);
        bus.i_abort = 1'b1;
        tick();
        chk("start+abort busy", bus.o_busy, 0);
        chk("start+abort load", bus.o_load_freq, 0);
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        capture(6, -1, 0);
        e_clear();
        check_run("start+abort after");

        // start_inc equal to stop_inc: one pulse, one dwell, done.
        cfg(77, 77, 5, 3, 0);
        capture(6, -1, 0);
        e_clear();
        e_load(0, 77);
        e_done.push_back(3);
        check_run("equal");

        // Start sampled in the done cycle relaunches with the new config.
        cfg(200, 5, 60, 1, 0);
        capture(14, 5, 150);
        e_clear();
        e_load(0, 200); e_load(1, 140); e_load(2, 80); e_load(3, 20); e_load(4, 5);
        e_load(6, 150); e_load(7, 90); e_load(8, 30); e_load(9, 5);
        e_done.push_back(5);
        e_done.push_back(10);
        check_run("start@done");

        // Reset mid-sweep, with start and abort also high.
        cfg(10, 40, 10, 4, 0);
        capture(6, -1, 0);
        reset       = 1'b1;
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        chk("midrst phase", bus.o_phase_inc, 1);
        chk("midrst busy", bus.o_busy, 0);
        chk("midrst load", bus.o_load_freq, 0);
        chk("midrst done", bus.o_done, 0);
        reset       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        capture(20, -1, 0);
        e_clear();
        check_run("after rst");
        chk("after rst phase", bus.o_phase_inc, 1);
        cfg(200, 5, 60, 1, 0);
        capture(8, -1, 0);
        e_clear();
        e_load(0, 200); e_load(1, 140); e_load(2, 80); e_load(3, 20); e_load(4, 5);
        e_done.push_back(5);
        check_run("relaunch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
